// File: rtl/i2c_m.sv
// Single-master I2C initiator: one 7-bit-addressed, single-byte write or read per request.
// Each bit is four quarters of CLK_DIV clocks; SDA/SCL are open drain (drive 0 or release).
module i2c_m #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   inout  wire        SDA,
   output wire        SCL
);
   localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_MNACK, S_STOP
   } state_t;

   state_t          state_reg, state_next;
   logic [QW-1:0]   qcnt_reg, qcnt_next;
   logic [1:0]      q_reg, q_next;
   logic [3:0]      bcnt_reg, bcnt_next;
   logic [7:0]      shift_reg, shift_next;
   logic [7:0]      wdata_reg, wdata_next;
   logic            rw_reg, rw_next;
   logic            samp_reg, samp_next;
   logic [7:0]      rdata_reg, rdata_next;
   logic            ack_err_reg, ack_err_next;
   logic            busy_reg, busy_next;
   logic            done_reg, done_next;
   logic            sda_low_reg, sda_low_next;
   logic            scl_low_reg, scl_low_next;
   logic            q_end;
   logic            sda_in;

   assign sda_in = SDA;

   always_comb begin
      state_next   = state_reg;
      qcnt_next    = qcnt_reg;
      q_next       = q_reg;
      bcnt_next    = bcnt_reg;
      shift_next   = shift_reg;
      wdata_next   = wdata_reg;
      rw_next      = rw_reg;
      samp_next    = samp_reg;
      rdata_next   = rdata_reg;
      ack_err_next = ack_err_reg;
      busy_next    = busy_reg;
      done_next    = 1'b0;
      q_end        = (qcnt_reg == QLAST);

      if (state_reg == S_IDLE) begin
         if (start) begin
            state_next   = S_START;
            qcnt_next    = '0;
            q_next       = 2'd0;
            shift_next   = {addr, rw};
            wdata_next   = wdata;
            rw_next      = rw;
            ack_err_next = 1'b0;
            busy_next    = 1'b1;
         end
      end else begin
         qcnt_next = q_end ? '0 : qcnt_reg + 1'b1;
         if (q_end) q_next = q_reg + 2'd1;
         // SDA is sampled on the last clk of Q2, while SCL is high and stable
         if (q_end && q_reg == 2'd2) begin
            samp_next = sda_in;
            if (state_reg == S_RDATA) shift_next = {shift_reg[6:0], sda_in};
         end
         if (q_end && q_reg == 2'd3) begin
            case (state_reg)
               S_START: begin
                  state_next = S_ADDR;
                  bcnt_next  = 4'd7;
               end
               S_ADDR, S_WDATA: begin
                  shift_next = {shift_reg[6:0], 1'b0};
                  if (bcnt_reg == 4'd0)
                     state_next = (state_reg == S_ADDR) ? S_AACK : S_WACK;
                  else
                     bcnt_next = bcnt_reg - 4'd1;
               end
               S_AACK: begin
                  bcnt_next = 4'd7;
                  if (samp_reg) begin
                     ack_err_next = 1'b1;
                     state_next   = S_STOP;
                  end else if (rw_reg) begin
                     state_next = S_RDATA;
                  end else begin
                     state_next = S_WDATA;
                     shift_next = wdata_reg;
                  end
               end
               S_WACK: begin
                  if (samp_reg) ack_err_next = 1'b1;
                  state_next = S_STOP;
               end
               S_RDATA: begin
                  if (bcnt_reg == 4'd0) begin
                     rdata_next = shift_reg;
                     state_next = S_MNACK;
                  end else begin
                     bcnt_next = bcnt_reg - 4'd1;
                  end
               end
               S_MNACK: state_next = S_STOP;
               S_STOP: begin
                  state_next = S_IDLE;
                  busy_next  = 1'b0;
                  done_next  = 1'b1;
               end
               default: state_next = S_IDLE;
            endcase
         end
      end

      // Pad drive is decoded from the next state so the pads come straight off flops
      sda_low_next = 1'b0;
      scl_low_next = 1'b0;
      case (state_next)
         S_IDLE: begin
         end
         S_START: sda_low_next = q_next[1];
         S_ADDR, S_WDATA: begin
            sda_low_next = ~shift_next[7];
            scl_low_next = ~q_next[1];
         end
         S_STOP: begin
            sda_low_next = (q_next != 2'd3);
            scl_low_next = ~q_next[1];
         end
         default: scl_low_next = ~q_next[1];
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= S_IDLE;
         qcnt_reg    <= '0;
         q_reg       <= 2'd0;
         bcnt_reg    <= 4'd0;
         shift_reg   <= 8'h00;
         wdata_reg   <= 8'h00;
         rw_reg      <= 1'b0;
         samp_reg    <= 1'b1;
         rdata_reg   <= 8'h00;
         ack_err_reg <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         sda_low_reg <= 1'b0;
         scl_low_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         qcnt_reg    <= qcnt_next;
         q_reg       <= q_next;
         bcnt_reg    <= bcnt_next;
         shift_reg   <= shift_next;
         wdata_reg   <= wdata_next;
         rw_reg      <= rw_next;
         samp_reg    <= samp_next;
         rdata_reg   <= rdata_next;
         ack_err_reg <= ack_err_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         sda_low_reg <= sda_low_next;
         scl_low_reg <= scl_low_next;
      end
   end

   assign SDA     = sda_low_reg ? 1'b0 : 1'bz;
   assign SCL     = scl_low_reg ? 1'b0 : 1'bz;
   assign rdata   = rdata_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;
   assign ack_err = ack_err_reg;

endmodule

// File: tb/tb_i2c_m.sv
// Directed bench for i2c_m with pull-ups and a behavioural single-byte responder at 7'h27.
// The responder also logs every bit seen on an SCL rise and counts START/STOP conditions.
module tb_i2c_m;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] addr = 7'h00;
   logic [7:0] wdata = 8'h00;
   logic [7:0] rdata;
   logic       busy, done, ack_err;
   wire        sda_w, scl_w;

   pullup (sda_w);
   pullup (scl_w);

   i2c_m #(.CLK_DIV(4)) dut (
      .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
      .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err),
      .SDA(sda_w), .SCL(scl_w)
   );

   always #5 clk = ~clk;

   int npass = 0;
   int nchk  = 0;

   // responder model
   localparam logic [6:0] SLV_ADDR = 7'h27;
   logic        sda_b, scl_b;
   logic        sda_p = 1'b1, scl_p = 1'b1;
   logic        slv_low = 1'b0;
   int          phase = 0;
   int          cnt = 0;
   logic [7:0]  sh = 8'h00;
   logic        rd = 1'b0;
   logic [7:0]  tx_byte = 8'h00;
   logic [7:0]  rx_byte = 8'h00;
   logic [63:0] bit_log = 64'h0;
   int          n_rise = 0;
   int          n_start = 0;
   int          n_stop = 0;

   assign sda_w = slv_low ? 1'b0 : 1'bz;
   assign sda_b = (sda_w !== 1'b0);
   assign scl_b = (scl_w !== 1'b0);

   always @(negedge clk) begin
      sda_p <= sda_b;
      scl_p <= scl_b;
      if (rst && scl_p && scl_b && (sda_p != sda_b)) begin
         if (!sda_b) begin
            n_start <= n_start + 1;
            phase   <= 1;
            cnt     <= 0;
         end else begin
            n_stop <= n_stop + 1;
            phase  <= 0;
         end
         slv_low <= 1'b0;
      end else if (!scl_p && scl_b) begin
         n_rise  <= n_rise + 1;
         bit_log <= {bit_log[62:0], sda_b};
         if (phase == 1 || phase == 3) begin
            sh  <= {sh[6:0], sda_b};
            cnt <= cnt + 1;
         end else if (phase == 5) begin
            cnt <= cnt + 1;
         end
      end else if (scl_p && !scl_b) begin
         case (phase)
            1: if (cnt == 8) begin
                  if (sh[7:1] == SLV_ADDR) begin
                     slv_low <= 1'b1;
                     rd      <= sh[0];
                     phase   <= 2;
                  end else begin
                     phase <= 0;
                  end
               end
            2: begin
                  cnt <= 0;
                  if (rd) begin
                     phase   <= 5;
                     slv_low <= ~tx_byte[7];
                  end else begin
                     phase   <= 3;
                     slv_low <= 1'b0;
                  end
               end
            3: if (cnt == 8) begin
                  rx_byte <= sh;
                  slv_low <= 1'b1;
                  phase   <= 4;
               end
            4: begin
                  slv_low <= 1'b0;
                  phase   <= 0;
               end
            5: if (cnt == 8) begin
                  slv_low <= 1'b0;
                  phase   <= 6;
               end else begin
                  slv_low <= ~tx_byte[7-cnt];
               end
            6: phase <= 0;
            default: phase <= 0;
         endcase
      end
   end

   // stimulus helpers (no comparisons inside)
   task automatic accept(input logic r, input logic [6:0] a, input logic [7:0] d);
      rw = r; addr = a; wdata = d; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int lat0, output int lat, output logic got);
      lat = lat0;
      while (!done && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
      end
      got = done;
   endtask

   task automatic test_reset;
      nchk++; if (sda_w !== 1'b1) $display("FAIL rst_sda: got %b, expected 1", sda_w); else npass++;
      nchk++; if (scl_w !== 1'b1) $display("FAIL rst_scl: got %b, expected 1", scl_w); else npass++;
      nchk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, expected 0", busy); else npass++;
      nchk++; if (done !== 1'b0) $display("FAIL rst_done: got %b, expected 0", done); else npass++;
      nchk++; if (ack_err !== 1'b0) $display("FAIL rst_ack_err: got %b, expected 0", ack_err); else npass++;
      nchk++; if (rdata !== 8'h00) $display("FAIL rst_rdata: got %h, expected 00", rdata); else npass++;
      $display("reset: busy=%b done=%b ack_err=%b rdata=%h", busy, done, ack_err, rdata);
   endtask

   task automatic test_write;
      int s0, p0, r0, lat;
      logic got;
      logic [18:0] exp_bits;
      exp_bits = {8'h4E, 1'b0, 8'hA5, 1'b0, 1'b0};
      s0 = n_start; p0 = n_stop; r0 = n_rise;
      accept(1'b0, 7'h27, 8'hA5);
      nchk++; if (busy !== 1'b1) $display("FAIL wr_busy: got %b, expected 1", busy); else npass++;
      wait_done(0, lat, got);
      nchk++; if (got !== 1'b1) $display("FAIL wr_done: got %b, expected 1", got); else npass++;
      nchk++; if (lat != 320) $display("FAIL wr_latency: got %0d, expected 320", lat); else npass++;
      nchk++; if (busy !== 1'b0) $display("FAIL wr_busy_fall: got %b, expected 0", busy); else npass++;
      nchk++; if (ack_err !== 1'b0) $display("FAIL wr_ack_err: got %b, expected 0", ack_err); else npass++;
      nchk++; if (rx_byte !== 8'hA5) $display("FAIL wr_slave_byte: got %h, expected a5", rx_byte); else npass++;
      nchk++; if (n_rise - r0 != 19) $display("FAIL wr_rises: got %0d, expected 19", n_rise - r0); else npass++;
      nchk++; if (bit_log[18:0] !== exp_bits) $display("FAIL wr_bits: got %h, expected %h", bit_log[18:0], exp_bits); else npass++;
      nchk++; if (n_start - s0 != 1 || n_stop - p0 != 1)
         $display("FAIL wr_start_stop: got %0d/%0d, expected 1/1", n_start - s0, n_stop - p0); else npass++;
      nchk++; if (rdata !== 8'h00) $display("FAIL wr_rdata_hold: got %h, expected 00", rdata); else npass++;
      $display("write a=27 d=a5: lat=%0d ack_err=%b slave=%h", lat, ack_err, rx_byte);
   endtask

   task automatic test_read;
      int s0, p0, r0, lat;
      logic got;
      logic [18:0] exp_bits;
      exp_bits = {8'h4F, 1'b0, 8'h3C, 1'b1, 1'b0};
      tx_byte = 8'h3C;
      s0 = n_start; p0 = n_stop; r0 = n_rise;
      accept(1'b1, 7'h27, 8'h00);
      wait_done(0, lat, got);
      nchk++; if (got !== 1'b1) $display("FAIL rd_done: got %b, expected 1", got); else npass++;
      nchk++; if (lat != 320) $display("FAIL rd_latency: got %0d, expected 320", lat); else npass++;
      nchk++; if (rdata !== 8'h3C) $display("FAIL rd_rdata: got %h, expected 3c", rdata); else npass++;
      nchk++; if (ack_err !== 1'b0) $display("FAIL rd_ack_err: got %b, expected 0", ack_err); else npass++;
      nchk++; if (n_rise - r0 != 19) $display("FAIL rd_rises: got %0d, expected 19", n_rise - r0); else npass++;
      nchk++; if (bit_log[18:0] !== exp_bits) $display("FAIL rd_bits: got %h, expected %h", bit_log[18:0], exp_bits); else npass++;
      nchk++; if (n_start - s0 != 1 || n_stop - p0 != 1)
         $display("FAIL rd_start_stop: got %0d/%0d, expected 1/1", n_start - s0, n_stop - p0); else npass++;
      $display("read a=27: lat=%0d rdata=%h ack_err=%b", lat, rdata, ack_err);
   endtask

   task automatic test_nack;
      int s0, p0, r0, lat;
      logic got;
      logic [9:0] exp_bits;
      exp_bits = {8'h60, 1'b1, 1'b0};
      s0 = n_start; p0 = n_stop; r0 = n_rise;
      accept(1'b0, 7'h30, 8'hFF);
      wait_done(0, lat, got);
      nchk++; if (got !== 1'b1) $display("FAIL nack_done: got %b, expected 1", got); else npass++;
      nchk++; if (lat != 176) $display("FAIL nack_latency: got %0d, expected 176", lat); else npass++;
      nchk++; if (ack_err !== 1'b1) $display("FAIL nack_ack_err: got %b, expected 1", ack_err); else npass++;
      nchk++; if (rdata !== 8'h3C) $display("FAIL nack_rdata_hold: got %h, expected 3c", rdata); else npass++;
      nchk++; if (n_rise - r0 != 10) $display("FAIL nack_rises: got %0d, expected 10", n_rise - r0); else npass++;
      nchk++; if (bit_log[9:0] !== exp_bits) $display("FAIL nack_bits: got %h, expected %h", bit_log[9:0], exp_bits); else npass++;
      nchk++; if (n_start - s0 != 1 || n_stop - p0 != 1)
         $display("FAIL nack_start_stop: got %0d/%0d, expected 1/1", n_start - s0, n_stop - p0); else npass++;
      $display("write a=30 (nack): lat=%0d ack_err=%b rdata=%h", lat, ack_err, rdata);
   endtask

   task automatic test_ignore_busy;
      int s0, lat;
      logic got;
      s0 = n_start;
      accept(1'b0, 7'h27, 8'hC3);
      nchk++; if (ack_err !== 1'b0) $display("FAIL ign_ack_err_clear: got %b, expected 0", ack_err); else npass++;
      repeat (50) @(posedge clk);
      #1;
      rw = 1'b1; addr = 7'h30; wdata = 8'h00; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(51, lat, got);
      nchk++; if (got !== 1'b1) $display("FAIL ign_done: got %b, expected 1", got); else npass++;
      nchk++; if (lat != 320) $display("FAIL ign_latency: got %0d, expected 320", lat); else npass++;
      nchk++; if (rx_byte !== 8'hC3) $display("FAIL ign_slave_byte: got %h, expected c3", rx_byte); else npass++;
      nchk++; if (ack_err !== 1'b0) $display("FAIL ign_ack_err: got %b, expected 0", ack_err); else npass++;
      nchk++; if (n_start - s0 != 1) $display("FAIL ign_starts: got %0d, expected 1", n_start - s0); else npass++;
      $display("write d=c3 with start pulsed while busy: lat=%0d slave=%h", lat, rx_byte);
   endtask

   task automatic test_back_to_back;
      int s0, p0, lat;
      logic got;
      s0 = n_start; p0 = n_stop;
      tx_byte = 8'h96;
      accept(1'b0, 7'h27, 8'h11);
      repeat (300) @(posedge clk);
      #1;
      rw = 1'b1; addr = 7'h27; wdata = 8'h00; start = 1'b1;
      wait_done(300, lat, got);
      nchk++; if (got !== 1'b1 || lat != 320) $display("FAIL b2b_first: got done=%b lat=%0d, expected 1/320", got, lat); else npass++;
      nchk++; if (busy !== 1'b0) $display("FAIL b2b_busy_done_cycle: got %b, expected 0", busy); else npass++;
      @(posedge clk); #1;
      start = 1'b0;
      nchk++; if (busy !== 1'b1 || done !== 1'b0)
         $display("FAIL b2b_accept: got busy=%b done=%b, expected 1/0", busy, done); else npass++;
      wait_done(0, lat, got);
      nchk++; if (got !== 1'b1 || lat != 320) $display("FAIL b2b_second: got done=%b lat=%0d, expected 1/320", got, lat); else npass++;
      nchk++; if (rdata !== 8'h96) $display("FAIL b2b_rdata: got %h, expected 96", rdata); else npass++;
      nchk++; if (rx_byte !== 8'h11) $display("FAIL b2b_slave_byte: got %h, expected 11", rx_byte); else npass++;
      nchk++; if (n_start - s0 != 2 || n_stop - p0 != 2)
         $display("FAIL b2b_start_stop: got %0d/%0d, expected 2/2", n_start - s0, n_stop - p0); else npass++;
      $display("back-to-back write d=11 then read: rdata=%h slave=%h", rdata, rx_byte);
   endtask

   task automatic test_reset_mid;
      int p0, lat;
      logic got;
      logic seen;
      accept(1'b0, 7'h27, 8'hA5);
      repeat (100) @(posedge clk);
      #1;
      p0 = n_stop;
      rst = 1'b0;
      #1;
      nchk++; if (sda_w !== 1'b1 || scl_w !== 1'b1)
         $display("FAIL rstm_pads: got sda=%b scl=%b, expected 1/1", sda_w, scl_w); else npass++;
      nchk++; if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL rstm_busy: got busy=%b done=%b, expected 0/0", busy, done); else npass++;
      nchk++; if (rdata !== 8'h00) $display("FAIL rstm_rdata: got %h, expected 00", rdata); else npass++;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      seen = 1'b0;
      repeat (400) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      nchk++; if (seen !== 1'b0) $display("FAIL rstm_no_done: got %b, expected 0", seen); else npass++;
      nchk++; if (n_stop != p0) $display("FAIL rstm_no_stop: got %0d, expected %0d", n_stop, p0); else npass++;
      accept(1'b0, 7'h27, 8'h5A);
      wait_done(0, lat, got);
      nchk++; if (got !== 1'b1 || lat != 320) $display("FAIL rstm_next: got done=%b lat=%0d, expected 1/320", got, lat); else npass++;
      nchk++; if (rx_byte !== 8'h5A) $display("FAIL rstm_slave_byte: got %h, expected 5a", rx_byte); else npass++;
      nchk++; if (ack_err !== 1'b0) $display("FAIL rstm_ack_err: got %b, expected 0", ack_err); else npass++;
      $display("reset mid-write then write d=5a: lat=%0d slave=%h", lat, rx_byte);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      test_reset;
      test_write;
      test_read;
      test_nack;
      test_ignore_busy;
      test_back_to_back;
      test_reset_mid;
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
